counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command-driven sequencer for the team's 4-bit up-counter datapath. Accepts LOAD/UP/DOWN/CLEAR commands over a valid/ready handshake and steps the count register the requested number of cycles. Supports pause (`hold`) and `abort`, and reports completion and wrap events. It sits between a host/testbench stimulus source and the count register, and replaces free-running count-on-every-edge behaviour.

## Interface
- `WIDTH`, 4, width of count value and step argument.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 2: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- `cmd_arg` in WIDTH: LOAD value, or step count N for UP/DOWN. Ignored for CLEAR.
- `hold` in 1: pause stepping while high.
- `abort` in 1: terminate an UP/DOWN run.
- `out` out WIDTH: current count, registered.
- `busy` out 1: high when state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `wrap` out 1: one-cycle pulse on modular wrap.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - RUN: stepping.
  - DONE: one cycle, `done`=1.
- Accept on the rising edge where `cmd_valid && cmd_ready`. `cmd_ready` = (state==IDLE) && !`rst`. It never depends on `cmd_valid`.
- LOAD: `out`←`cmd_arg`, then IDLE→DONE.
- CLEAR: `out`←0, then IDLE→DONE.
- UP/DOWN, N≠0: latch direction, `rem`←N, then IDLE→RUN.
- UP/DOWN, N=0: `out` unchanged, then IDLE→DONE.
- RUN:
  - Each edge with `hold`=0: `out`←`out`±1 mod 2^WIDTH and `rem`←`rem`−1.
  - If `rem`==1 at that edge, go to DONE.
  - `hold`=1: `out` and `rem` frozen, no pulses.
- Priority: `rst` > `abort` > `hold` > step.
- `abort` in RUN: go to IDLE at that edge. `out` keeps its last value, no step is taken, and `done` is not pulsed.
- `abort` in IDLE or DONE has no effect. A DONE pulse still completes.
- `wrap`: high in the cycle after an edge where `out` moved 15→0 (UP) or 0→15 (DOWN). LOAD and CLEAR never raise `wrap`.
- DONE → IDLE unconditionally on the next edge. Commands are not accepted in DONE.
- Arithmetic: `rem` is WIDTH bits, so max N = 2^WIDTH−1. N=15 with UP from 0 ends at 15 with no wrap.

## Timing
- Reset values: `out`=0, `done`=0, `wrap`=0, `busy`=0, state=IDLE. `cmd_ready`=0 while `rst` is high and 1 in the first cycle after it deasserts.
- Reset in any state (mid-RUN, DONE) forces the reset values at that edge. Pending `rem` is discarded.
- LOAD/CLEAR accepted at edge e0:
  - `out` updated and `done`=1 in the cycle after e0.
  - `cmd_ready`=1 again after e1.
- UP/DOWN N accepted at e0, no hold:
  - `out` changes at e1…eN.
  - `done`=1 in the cycle after eN.
  - IDLE after eN+1.
  - Total N+2 cycles accept-to-ready.
  - Each `hold` cycle adds exactly one cycle.
- `busy` is high from the cycle after acceptance through the DONE cycle.
- Back-to-back commands: minimum spacing equals the command latency above. There is no queueing.

## Structure
- Package `counter_ctrl_pkg`:
  - op localparams `OP_LOAD`, `OP_UP`, `OP_DOWN`, `OP_CLEAR`.
  - state encoding `ST_IDLE`, `ST_RUN`, `ST_DONE`.
  - default `WIDTH`.
- Sub-module `count_core`: WIDTH-bit register with synchronous `rst`, plus `load`/`load_val`, `en`, `dir` and a `wrap` flag output.
- `counter_ctrl` holds the FSM, `rem` down-counter, handshake logic and the registered `done`/`wrap` pulses.

## Test plan
- Reset then LOAD 9:
  - `rst` held 2 cycles, then LOAD `cmd_arg`=9.
  - Expect `out`=9 and `done`=1 one cycle after accept, then `cmd_ready` back high.
- UP with wrap:
  - LOAD 13, then UP N=4.
  - Expect `out` sequence 14, 15, 0, 1.
  - `wrap`=1 only in the cycle after 15→0.
  - `done` in the cycle after `out`=1.
- DOWN with hold and N=0:
  - `out`=2, DOWN N=3, with `hold` high for 2 cycles after the first step.
  - Expect 1, (1, 1), 0, 15; `wrap` once; `done` 2 cycles later than the no-hold case.
  - Then DOWN N=0: `done` next cycle, `out` unchanged.
- Abort mid-run:
  - `out`=0, UP N=10, `abort` asserted on the edge after `out` reaches 4.
  - Expect `out` stays 4, `done` never pulses, `busy`=0, `cmd_ready`=1.
- Reset mid-run and ignored valid:
  - UP N=8 from 0, `rst` asserted after `out`=3.
  - Expect `out`=0, `busy`=0, no `done`.
  - `cmd_valid` held during RUN with CLEAR is ignored until IDLE and is then accepted exactly once.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the command-driven counter sequencer.
//   WIDTH_DEFAULT : default width of the count value and step argument
//   OP_*          : cmd_op encodings
//   state_e       : controller state encoding
package counter_ctrl_pkg;

   localparam int WIDTH_DEFAULT = 4;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/counter_ctrl_count_core.sv
// WIDTH-bit count register with parallel load and +/-1 stepping.
//   clk, rst  : clock, synchronous active-high reset
//   load      : take load_val this edge (wins over en)
//   load_val  : value to load
//   en        : step this edge
//   dir       : 0 = up, 1 = down
//   count     : registered count
//   wrap      : high when the step taken at the coming edge wraps modulo 2^WIDTH
module count_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      wrap    = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         if (dir) begin
            count_d = count_q - ONE;
            wrap    = (count_q == '0);
         end else begin
            count_d = count_q + ONE;
            wrap    = (count_q == '1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the up/down count register.
//   clk, rst   : clock, synchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : command can be accepted (IDLE and not in reset)
//   cmd_op     : LOAD / UP / DOWN / CLEAR
//   cmd_arg    : LOAD value or step count for UP/DOWN
//   hold       : freeze stepping while high
//   abort      : end an UP/DOWN run immediately, without done
//   out        : registered count
//   busy       : state is not IDLE
//   done       : one-cycle completion pulse
//   wrap       : one-cycle pulse after a modular wrap step
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | waiting for a command, cmd_ready high
// ST_RUN  | stepping out by one per non-held edge
// ST_DONE | one cycle, done pulse visible
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             wrap_q, wrap_d;

   logic             accept;
   logic             core_load;
   logic [WIDTH-1:0] core_load_val;
   logic             core_en;
   logic             core_wrap;

   assign cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      dir_d         = dir_q;
      core_load     = 1'b0;
      core_load_val = '0;
      core_en       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               unique case (cmd_op)
                  OP_LOAD: begin
                     core_load     = 1'b1;
                     core_load_val = cmd_arg;
                     state_d       = ST_DONE;
                  end
                  OP_CLEAR: begin
                     core_load = 1'b1;
                     state_d   = ST_DONE;
                  end
                  default: begin
                     // UP/DOWN with zero steps completes without touching out
                     if (cmd_arg != '0) begin
                        dir_d   = (cmd_op == OP_DOWN);
                        rem_d   = cmd_arg;
                        state_d = ST_RUN;
                     end else begin
                        state_d = ST_DONE;
                     end
                  end
               endcase
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!hold) begin
               core_en = 1'b1;
               rem_d   = rem_q - ONE;
               if (rem_q == ONE) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      done_d = (state_d == ST_DONE);
      wrap_d = core_wrap;
   end

   count_core #(
      .WIDTH (WIDTH)
   ) u_count_core (
      .clk      (clk),
      .rst      (rst),
      .load     (core_load),
      .load_val (core_load_val),
      .en       (core_en),
      .dir      (dir_q),
      .count    (out),
      .wrap     (core_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

   localparam logic [1:0] C_LOAD  = 2'b00;
   localparam logic [1:0] C_UP    = 2'b01;
   localparam logic [1:0] C_DOWN  = 2'b10;
   localparam logic [1:0] C_CLEAR = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_arg = 4'd0;
   logic       hold = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] out_w;
   logic       busy;
   logic       done;
   logic       wrap;

   int vectors = 0;
   int miscompares = 0;
   int m_out = 0;

   counter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .hold      (hold),
      .abort     (abort),
      .out       (out_w),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (out_w !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_vals: out=%0d busy=%b done=%b wrap=%b, want 0 0 0 0", out_w, busy, done, wrap);
      end
      vectors++;
      if (cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: cmd_ready=%b want 0", cmd_ready);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_after_reset: cmd_ready=%b want 1", cmd_ready);
      end
      m_out = 0;
   endtask

   task automatic test_load;
      issue(C_LOAD, 4'd9);
      m_out = 9;
      vectors++;
      if (out_w !== 4'd9 || done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL load9: out=%0d done=%b busy=%b ready=%b, want 9 1 1 0", out_w, done, busy, cmd_ready);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL load9_idle: done=%b ready=%b busy=%b, want 0 1 0", done, cmd_ready, busy);
      end
   endtask

   task automatic test_up_wrap;
      int e;
      issue(C_LOAD, 4'd13);
      tick();
      issue(C_UP, 4'd4);
      for (int k = 1; k <= 4; k++) begin
         tick();
         e = (13 + k) % 16;
         vectors++;
         if (out_w !== 4'(e) || wrap !== (e == 0) || done !== (k == 4) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL up_wrap step %0d: out=%0d wrap=%b done=%b busy=%b, want %0d %b %b 1",
                     k, out_w, wrap, done, busy, e, (e == 0), (k == 4));
         end
      end
      tick();
      vectors++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || out_w !== 4'd1) begin
         miscompares++;
         $display("FAIL up_wrap_end: done=%b ready=%b out=%0d, want 0 1 1", done, cmd_ready, out_w);
      end
      m_out = 1;
   endtask

   task automatic test_down_hold;
      int exp_seq [6] = '{1, 1, 1, 0, 15, 15};
      int exp_wrp [6] = '{0, 0, 0, 0, 1, 0};
      int exp_dn  [6] = '{0, 0, 0, 0, 1, 0};
      issue(C_LOAD, 4'd2);
      tick();
      issue(C_DOWN, 4'd3);
      for (int c = 0; c < 6; c++) begin
         hold = (c == 1 || c == 2);
         tick();
         hold = 1'b0;
         vectors++;
         if (out_w !== 4'(exp_seq[c]) || wrap !== exp_wrp[c][0] || done !== exp_dn[c][0]) begin
            miscompares++;
            $display("FAIL down_hold cyc %0d: out=%0d wrap=%b done=%b, want %0d %0d %0d",
                     c, out_w, wrap, done, exp_seq[c], exp_wrp[c], exp_dn[c]);
         end
      end
      issue(C_DOWN, 4'd0);
      vectors++;
      if (done !== 1'b1 || out_w !== 4'd15 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL down_n0: done=%b out=%0d wrap=%b, want 1 15 0", done, out_w, wrap);
      end
      tick();
      vectors++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL down_n0_idle: ready=%b done=%b, want 1 0", cmd_ready, done);
      end
      m_out = 15;
   endtask

   task automatic test_abort;
      issue(C_CLEAR, 4'd0);
      tick();
      issue(C_UP, 4'd10);
      repeat (4) tick();
      vectors++;
      if (out_w !== 4'd4) begin
         miscompares++;
         $display("FAIL abort_pre: out=%0d want 4", out_w);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      vectors++;
      if (out_w !== 4'd4 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL abort: out=%0d busy=%b ready=%b done=%b, want 4 0 1 0", out_w, busy, cmd_ready, done);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || out_w !== 4'd4) begin
         miscompares++;
         $display("FAIL abort_after: done=%b out=%0d, want 0 4", done, out_w);
      end
      m_out = 4;
   endtask

   task automatic test_reset_midrun;
      issue(C_CLEAR, 4'd0);
      tick();
      issue(C_UP, 4'd8);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      vectors++;
      if (out_w !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_midrun: out=%0d busy=%b done=%b ready=%b, want 0 0 0 0", out_w, busy, done, cmd_ready);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if (done !== 1'b0 || out_w !== 4'd0 || cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_midrun_after: done=%b out=%0d ready=%b, want 0 0 1", done, out_w, cmd_ready);
      end
   endtask

   task automatic test_back_to_back;
      int exp_o [6] = '{6, 7, 8, 8, 0, 0};
      int exp_d [6] = '{0, 0, 1, 0, 1, 0};
      int exp_r [6] = '{0, 0, 0, 1, 0, 1};
      issue(C_LOAD, 4'd5);
      tick();
      issue(C_UP, 4'd3);
      cmd_valid = 1'b1;
      cmd_op    = C_CLEAR;
      cmd_arg   = 4'd7;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c == 4) cmd_valid = 1'b0;
         vectors++;
         if (out_w !== 4'(exp_o[c]) || done !== exp_d[c][0] || cmd_ready !== exp_r[c][0]) begin
            miscompares++;
            $display("FAIL held_valid cyc %0d: out=%0d done=%b ready=%b, want %0d %0d %0d",
                     c, out_w, done, cmd_ready, exp_o[c], exp_d[c], exp_r[c]);
         end
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || out_w !== 4'd0) begin
         miscompares++;
         $display("FAIL held_valid_once: done=%b busy=%b out=%0d, want 0 0 0", done, busy, out_w);
      end
      m_out = 0;
   endtask

   task automatic test_random;
      logic [1:0] op;
      int n, d, prev, steps, abort_at, guard;
      bit use_abort, aborted, h, ab, exp_wrap;
      repeat (60) begin
         op        = 2'($urandom_range(0, 3));
         n         = $urandom_range(0, 15);
         use_abort = ($urandom_range(0, 5) == 0);
         abort_at  = (n > 0) ? $urandom_range(0, n - 1) : 0;
         vectors++;
         if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd_ready: cmd_ready=%b want 1", cmd_ready);
         end
         issue(op, 4'(n));
         if (op == C_LOAD || op == C_CLEAR || n == 0) begin
            if (op == C_LOAD) m_out = n;
            if (op == C_CLEAR) m_out = 0;
            vectors++;
            if (out_w !== 4'(m_out) || done !== 1'b1 || wrap !== 1'b0 || busy !== 1'b1) begin
               miscompares++;
               $display("FAIL rnd_single op=%0d arg=%0d: out=%0d done=%b wrap=%b busy=%b, want %0d 1 0 1",
                        op, n, out_w, done, wrap, busy, m_out);
            end
            aborted = 1'b0;
         end else begin
            d       = (op == C_UP) ? 1 : -1;
            steps   = 0;
            aborted = 1'b0;
            guard   = 0;
            while (steps < n && !aborted && guard < 200) begin
               guard++;
               h     = ($urandom_range(0, 3) == 0);
               ab    = use_abort && (steps == abort_at) && ($urandom_range(0, 1) == 1);
               hold  = h;
               abort = ab;
               prev  = m_out;
               tick();
               hold  = 1'b0;
               abort = 1'b0;
               vectors++;
               if (ab) begin
                  aborted = 1'b1;
                  if (out_w !== 4'(m_out) || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
                     miscompares++;
                     $display("FAIL rnd_abort: out=%0d busy=%b done=%b ready=%b, want %0d 0 0 1",
                              out_w, busy, done, cmd_ready, m_out);
                  end
               end else if (h) begin
                  if (out_w !== 4'(m_out) || wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                     miscompares++;
                     $display("FAIL rnd_hold: out=%0d wrap=%b done=%b busy=%b, want %0d 0 0 1",
                              out_w, wrap, done, busy, m_out);
                  end
               end else begin
                  steps++;
                  m_out    = (m_out + d + 16) % 16;
                  exp_wrap = (d > 0) ? (prev == 15) : (prev == 0);
                  if (out_w !== 4'(m_out) || wrap !== exp_wrap || done !== (steps == n) || busy !== 1'b1) begin
                     miscompares++;
                     $display("FAIL rnd_step op=%0d n=%0d step=%0d: out=%0d wrap=%b done=%b, want %0d %b %b",
                              op, n, steps, out_w, wrap, done, m_out, exp_wrap, (steps == n));
                  end
               end
            end
            if (guard >= 200) begin
               vectors++;
               miscompares++;
               $display("FAIL rnd_timeout: run did not finish within cycle budget");
            end
         end
         if (!aborted) begin
            abort = ($urandom_range(0, 1) == 1);
            tick();
            abort = 1'b0;
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || wrap !== 1'b0 || out_w !== 4'(m_out)) begin
               miscompares++;
               $display("FAIL rnd_idle: done=%b busy=%b ready=%b wrap=%b out=%0d, want 0 0 1 0 %0d",
                        done, busy, cmd_ready, wrap, out_w, m_out);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_up_wrap();
      test_down_hold();
      test_abort();
      test_reset_midrun();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
